// File: rtl/turn_sequencer.sv
// Turn sequencer for a phase-based game loop: walks through NUM_PHASES turn
// phases, tracks player/enemy hit points and completed rounds, and decides
// the winner. It also composites the active phase pixel with the HUD overlay.
//
// Ports
//   clk, rst               system clock, asynchronous active-low reset
//   phase_finished_in      level "finished" flag from each phase block
//   player_dmg_in          damage applied to the player each cycle (0 = none)
//   enemy_dmg_in           damage applied to the enemy each cycle (0 = none)
//   restart_in             level request to leave GAME_OVER
//   phase_pixel_in         RGB444 pixel of each phase, phase k at [12k+11:12k]
//   overlay_pixel_in       RGB444 health-bar/HUD pixel
//   phase_out              index of the active phase
//   phase_start_out        one-cycle pulse on entry to a phase
//   round_rst_out          one-cycle pulse resetting the phase blocks at round end
//   timeout_out            one-cycle pulse when the watchdog forces an advance
//   player_hp_out          player hit points
//   enemy_hp_out           enemy hit points
//   round_count_out        completed rounds, saturating
//   game_over_out          high while in GAME_OVER
//   winner_out             00 none, 01 player wins, 10 enemy wins, 11 draw
//   pixel_out              composited pixel (combinational)
module turn_sequencer #(
   parameter int unsigned NUM_PHASES     = 3,
   parameter int unsigned HP_W           = 8,
   parameter int unsigned MAX_HP         = 100,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned ROUND_W        = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PHASES-1:0]         phase_finished_in,
   input  logic [HP_W-1:0]               player_dmg_in,
   input  logic [HP_W-1:0]               enemy_dmg_in,
   input  logic                          restart_in,
   input  logic [12*NUM_PHASES-1:0]      phase_pixel_in,
   input  logic [11:0]                   overlay_pixel_in,
   output logic [$clog2(NUM_PHASES)-1:0] phase_out,
   output logic                          phase_start_out,
   output logic                          round_rst_out,
   output logic                          timeout_out,
   output logic [HP_W-1:0]               player_hp_out,
   output logic [HP_W-1:0]               enemy_hp_out,
   output logic [ROUND_W-1:0]            round_count_out,
   output logic                          game_over_out,
   output logic [1:0]                    winner_out,
   output logic [11:0]                   pixel_out
);

   localparam int unsigned PH_W    = $clog2(NUM_PHASES);
   localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic        WD_EN   = (TIMEOUT_CYCLES > 0);

   localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);
   localparam logic [HP_W-1:0] HP_RELOAD  = HP_W'(MAX_HP);

   localparam logic [1:0] S_START     = 2'd0;
   localparam logic [1:0] S_ACTIVE    = 2'd1;
   localparam logic [1:0] S_ROUND_END = 2'd2;
   localparam logic [1:0] S_GAME_OVER = 2'd3;

   logic [1:0]            state, state_nxt;
   logic [NUM_PHASES-1:0] fin_hist;
   logic [WD_W-1:0]       wd_cnt, wd_nxt;
   logic [PH_W-1:0]       phase_nxt;
   logic                  start_nxt, round_rst_nxt, timeout_nxt;
   logic [HP_W-1:0]       player_hp_nxt, enemy_hp_nxt;
   logic [ROUND_W-1:0]    round_nxt;
   logic [1:0]            winner_nxt;
   logic [NUM_PHASES-1:0] fin_rise;
   logic                  finish;
   logic                  expire;
   logic [11:0]           sel_px;
   logic [4:0]            chan_sum;

   // Rising edge of the active phase's finish flag; other phases are ignored.
   assign fin_rise = phase_finished_in & ~fin_hist;

   always_comb begin
      finish = 1'b0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         if (phase_out == PH_W'(k)) finish = fin_rise[k];
      end
   end

   assign expire = WD_EN && (state == S_ACTIVE) && (wd_cnt == WD_W'(WD_LAST));

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      phase_nxt     = phase_out;
      wd_nxt        = wd_cnt;
      start_nxt     = 1'b0;
      round_rst_nxt = 1'b0;
      timeout_nxt   = 1'b0;
      player_hp_nxt = player_hp_out;
      enemy_hp_nxt  = enemy_hp_out;
      round_nxt     = round_count_out;
      winner_nxt    = winner_out;

      if (state != S_GAME_OVER) begin
         player_hp_nxt = (player_hp_out > player_dmg_in) ? player_hp_out - player_dmg_in : '0;
         enemy_hp_nxt  = (enemy_hp_out > enemy_dmg_in) ? enemy_hp_out - enemy_dmg_in : '0;
      end

      case (state)
         S_START: begin
            start_nxt = 1'b1;
            wd_nxt    = '0;
            state_nxt = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (finish || expire) begin
               // A finish landing on the expiry cycle wins; no timeout is reported.
               timeout_nxt = expire && !finish;
               wd_nxt      = '0;
               if (phase_out == LAST_PHASE) begin
                  state_nxt = S_ROUND_END;
               end else begin
                  phase_nxt = phase_out + PH_W'(1);
                  state_nxt = S_START;
               end
            end else if (WD_EN) begin
               wd_nxt = wd_cnt + WD_W'(1);
            end
         end
         S_ROUND_END: begin
            round_rst_nxt = 1'b1;
            if (round_count_out != '1) round_nxt = round_count_out + ROUND_W'(1);
            phase_nxt = '0;
            state_nxt = S_START;
         end
         S_GAME_OVER: begin
            if (restart_in) begin
               player_hp_nxt = HP_RELOAD;
               enemy_hp_nxt  = HP_RELOAD;
               round_nxt     = '0;
               winner_nxt    = 2'b00;
               phase_nxt     = '0;
               state_nxt     = S_START;
            end
         end
         default: state_nxt = S_START;
      endcase

      // A dead side ends the game and overrides any phase/round activity.
      if ((state != S_GAME_OVER) && ((player_hp_out == '0) || (enemy_hp_out == '0))) begin
         state_nxt     = S_GAME_OVER;
         phase_nxt     = phase_out;
         round_nxt     = round_count_out;
         wd_nxt        = '0;
         start_nxt     = 1'b0;
         round_rst_nxt = 1'b0;
         timeout_nxt   = 1'b0;
         winner_nxt    = {player_hp_out == '0, enemy_hp_out == '0};
      end
   end

   // State and registered outputs. The finish history samples the flags every
   // cycle, including START, so a flag already high on phase entry is not a finish.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_START;
         phase_out       <= '0;
         wd_cnt          <= '0;
         fin_hist        <= '0;
         phase_start_out <= 1'b0;
         round_rst_out   <= 1'b0;
         timeout_out     <= 1'b0;
         player_hp_out   <= HP_RELOAD;
         enemy_hp_out    <= HP_RELOAD;
         round_count_out <= '0;
         game_over_out   <= 1'b0;
         winner_out      <= 2'b00;
      end else begin
         state           <= state_nxt;
         phase_out       <= phase_nxt;
         wd_cnt          <= wd_nxt;
         fin_hist        <= phase_finished_in;
         phase_start_out <= start_nxt;
         round_rst_out   <= round_rst_nxt;
         timeout_out     <= timeout_nxt;
         player_hp_out   <= player_hp_nxt;
         enemy_hp_out    <= enemy_hp_nxt;
         round_count_out <= round_nxt;
         game_over_out   <= (state_nxt == S_GAME_OVER);
         winner_out      <= winner_nxt;
      end
   end

   // Pixel compositing: per-channel saturating add, phase pixel blanked in GAME_OVER.
   always_comb begin
      sel_px    = '0;
      chan_sum  = '0;
      pixel_out = overlay_pixel_in;
      for (int k = 0; k < NUM_PHASES; k++) begin
         if (phase_out == PH_W'(k)) sel_px = phase_pixel_in[12*k +: 12];
      end
      if (state != S_GAME_OVER) begin
         for (int c = 0; c < 3; c++) begin
            chan_sum = {1'b0, sel_px[4*c +: 4]} + {1'b0, overlay_pixel_in[4*c +: 4]};
            pixel_out[4*c +: 4] = chan_sum[4] ? 4'hF : chan_sum[3:0];
         end
      end
   end

endmodule
